dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 ADDR_W, 32, requester and memory address width.
REQ-002 DATA_W, 32, read/write data width.
REQ-003 TIMEOUT_CYCLES, 255, max WAIT cycles before error completion (1..255).
REQ-004 clk_in  input  1  single clock; all state on rising edge.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  2  per-requester request (bit0 CPU data port, bit1 DMA/video).
REQ-007 req_ready  output  2  per-requester accept; one-hot or zero.
REQ-008 req_write  input  2  1 = store, 0 = load.
REQ-009 req_addr  input  2xADDR_W  request address.
REQ-010 req_width  input  2x2  mem width (BYTE/WORD/DWORD, shared mem package type).
REQ-011 req_wdata  input  2xDATA_W  store data.
REQ-012 rsp_valid  output  2  one-cycle completion pulse to owning requester.
REQ-013 rsp_err  output  2  completion was a timeout; qualified by rsp_valid.
REQ-014 rsp_rdata  output  DATA_W  load data, shared; valid with rsp_valid of a load, 0 for stores/errors.
REQ-015 mem_dispatch_read  output  1  one-cycle load dispatch.
REQ-016 mem_dispatch_write  output  1  one-cycle store dispatch.
REQ-017 mem_addr  output  ADDR_W  latched address.
REQ-018 mem_width  output  2  latched width.
REQ-019 mem_write_data  output  DATA_W  latched store data.
REQ-020 mem_busy  input  1  memory busy; rises no later than cycle after dispatch.
REQ-021 mem_read_data  input  DATA_W  load data, valid when mem_busy falls.

Function
REQ-022 FSM states IDLE, ISSUE, WAIT; IDLE->ISSUE on handshake, ISSUE->WAIT unconditionally, WAIT->IDLE on completion or timeout.
REQ-023 req_ready high (combinational) only in IDLE with mem_busy=0, only for the arbitration winner.
REQ-024 Handshake = req_valid&req_ready; at that edge addr/width/wdata/write/owner latch into holding registers.
REQ-025 Arbitration round-robin: single requester wins alone; both valid -> requester not granted last; after reset, requester 0 preferred.
REQ-026 ISSUE: exactly one cycle of mem_dispatch_read or mem_dispatch_write per latched write bit; mem_addr/width/write_data hold latched values from ISSUE through WAIT.
REQ-027 WAIT: first cycle with mem_busy=0 (not the first WAIT cycle unless mem_busy already seen high) completes; load samples mem_read_data.
REQ-028 Completion: rsp_valid[owner]=1, rsp_err=0 for exactly the next cycle, rsp_rdata registered; FSM in IDLE that same cycle, so a new handshake may coincide with rsp_valid.
REQ-029 Minimum occupancy 4 cycles per transaction (accept, issue, wait>=1, response overlap with next accept).
REQ-030 Timeout: 8-bit counter cleared in ISSUE, +1 per WAIT cycle; reaching TIMEOUT_CYCLES -> rsp_valid[owner]=1, rsp_err[owner]=1, rsp_rdata=0, FSM to IDLE.
REQ-031 req_valid dropped before handshake: nothing latched; arbiter pointer unchanged.
REQ-032 Requests arriving during ISSUE/WAIT see req_ready=0 and hold.
REQ-033 Dispatch outputs 0 in IDLE and WAIT; rsp_valid never asserted for both bits.

Reset
REQ-034 rst_in low asynchronously forces: state IDLE, all outputs 0, holding registers 0, counter 0, RR pointer to prefer requester 0.
REQ-035 Reset mid-ISSUE/WAIT abandons transaction silently; no rsp_valid issued after release.

Structure
REQ-036 FSM state enum and TIMEOUT_CYCLES default belong in the shared mem package alongside the width type.
REQ-037 One sub-module rr_arb2 (two-input round-robin grant with registered last-grant pointer).

Verification
REQ-038 Single CPU load addr 0x100, mem_busy 3 cycles, data 0xDEADBEEF -> one dispatch_read, rsp_valid[0] pulse, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-039 Both valid continuously, 4 stores -> grants 0,1,0,1; each mem_write_data matches owner's wdata.
REQ-040 mem_busy held high 255 WAIT cycles -> rsp_valid[1]=1, rsp_err[1]=1, rsp_rdata=0, returns IDLE.
REQ-041 rst_in low during WAIT -> all outputs 0 immediately; after release, no rsp_valid; next request served normally.
REQ-042 Back-to-back CPU loads, mem_busy 1 cycle -> new handshake coincides with previous rsp_valid; 4-cycle spacing between dispatches.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared memory-port types, arbiter FSM states and timeout default.
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {
    MW_BYTE  = 2'd0,
    MW_WORD  = 2'd1,
    MW_DWORD = 2'd2
  } mem_width_e;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant; the registered pointer remembers the last winner.
module rr_arb2 (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;
  always_comb begin
    gnt_o  = (req_i == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req_i;
    last_d = adv_i ? gnt_o[1] : last_q;
  end
  // Pointer resets to "requester 1 went last" so requester 0 wins the first tie.
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) last_q <= 1'b1;
    else         last_q <= last_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester data-memory arbiter with single outstanding access and timeout.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_write,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][1:0]        req_width,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [1:0]             rsp_err,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   mem_dispatch_read,
  output logic                   mem_dispatch_write,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [1:0]             mem_width,
  output logic [DATA_W-1:0]      mem_write_data,
  input  logic                   mem_busy,
  input  logic [DATA_W-1:0]      mem_read_data
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  mem_width_e        width_q, width_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              owner_q, owner_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              seen_q, seen_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0] gnt;
  logic       idle_free, hs, sel, done, timeout;

  rr_arb2 u_rr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .req_i  (req_valid),
    .adv_i  (hs),
    .gnt_o  (gnt)
  );

  // Ready is also gated by reset so every output is 0 while rst_in is low.
  assign idle_free = rst_in && (state_q == ST_IDLE) && !mem_busy;
  assign req_ready = gnt & {2{idle_free}};
  assign hs        = |(req_valid & req_ready);
  assign sel       = gnt[1];
  // The first WAIT cycle only completes if busy was already observed during ISSUE.
  assign done      = !mem_busy && (cnt_q != 8'd0 || seen_q);
  assign timeout   = cnt_q == TO_LAST;

  assign mem_dispatch_read  = (state_q == ST_ISSUE) && !write_q;
  assign mem_dispatch_write = (state_q == ST_ISSUE) && write_q;
  assign mem_addr           = addr_q;
  assign mem_width          = width_q;
  assign mem_write_data     = wdata_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_err            = rsp_err_q;
  assign rsp_rdata          = rdata_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    width_d     = width_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = 2'b00;
    rdata_d     = '0;
    case (state_q)
      ST_IDLE: if (hs) begin
        state_d = ST_ISSUE;
        addr_d  = req_addr[sel];
        width_d = mem_width_e'(req_width[sel]);
        wdata_d = req_wdata[sel];
        write_d = req_write[sel];
        owner_d = sel;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = 8'd0;
        seen_d  = mem_busy;
      end
      ST_WAIT: begin
        cnt_d  = cnt_q + 8'd1;
        seen_d = seen_q | mem_busy;
        if (done) begin
          state_d     = ST_IDLE;
          rsp_valid_d = owner_onehot(owner_q);
          rdata_d     = write_q ? '0 : mem_read_data;
        end else if (timeout) begin
          state_d     = ST_IDLE;
          rsp_valid_d = owner_onehot(owner_q);
          rsp_err_d   = owner_onehot(owner_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      width_q     <= MW_BYTE;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= 8'd0;
      seen_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      width_q     <= width_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;
  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [1:0]        req_valid = '0, req_write = '0;
  logic [1:0][31:0]  req_addr = '0, req_wdata = '0;
  logic [1:0][1:0]   req_width = '0;
  logic              mem_busy = 1'b0;
  logic [31:0]       mem_read_data = '0;
  logic [1:0]        req_ready, rsp_valid, rsp_err, mem_width;
  logic [31:0]       rsp_rdata, mem_addr, mem_write_data;
  logic              mem_dispatch_read, mem_dispatch_write;
  int checks = 0, passed = 0, cyc = 0, c0 = 0;

  dmem_arbiter dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_addr           (req_addr),
    .req_width          (req_width),
    .req_wdata          (req_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_err            (rsp_err),
    .rsp_rdata          (rsp_rdata),
    .mem_dispatch_read  (mem_dispatch_read),
    .mem_dispatch_write (mem_dispatch_write),
    .mem_addr           (mem_addr),
    .mem_width          (mem_width),
    .mem_write_data     (mem_write_data),
    .mem_busy           (mem_busy),
    .mem_read_data      (mem_read_data)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #2 rst_in = 1'b0;
    req_valid = 2'b01;
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dispatch", {mem_dispatch_read, mem_dispatch_write}, 2'b00);
    req_valid = 2'b00;
    tick();
    rst_in = 1'b1;
    tick();
    // single CPU load, busy for 3 cycles
    req_addr[0] = 32'h100; req_width[0] = 2'd1; req_write = 2'b00; req_valid = 2'b01;
    #1 chk("ld_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00; #1;
    chk("ld_disp_rd", mem_dispatch_read, 1);
    chk("ld_disp_wr", mem_dispatch_write, 0);
    chk("ld_addr", mem_addr, 32'h100);
    chk("ld_width", mem_width, 2'd1);
    chk("ld_busy_ready", req_ready, 2'b00);
    tick(); mem_busy = 1'b1; #1;
    chk("ld_wait_disp", mem_dispatch_read, 0);
    tick(); tick();
    tick(); mem_busy = 1'b0; mem_read_data = 32'hDEADBEEF;
    chk("ld_no_early_rsp", rsp_valid, 2'b00);
    chk("ld_hold_addr", mem_addr, 32'h100);
    tick();
    chk("ld_rsp_valid", rsp_valid, 2'b01);
    chk("ld_rsp_err", rsp_err, 2'b00);
    chk("ld_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    tick();
    chk("ld_rsp_pulse", rsp_valid, 2'b00);
    // DMA load that times out after 255 WAIT cycles
    req_addr[1] = 32'h400; req_valid = 2'b10;
    #1 chk("to_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00; mem_read_data = 32'h12345678;
    tick(); mem_busy = 1'b1;
    repeat (254) tick();
    chk("to_not_yet", rsp_valid, 2'b00);
    tick();
    chk("to_rsp_valid", rsp_valid, 2'b10);
    chk("to_rsp_err", rsp_err, 2'b10);
    chk("to_rsp_rdata", rsp_rdata, 0);
    req_valid = 2'b01; #1;
    chk("to_busy_blocks", req_ready, 2'b00);
    req_valid = 2'b00; mem_busy = 1'b0;
    tick();
    chk("to_rsp_pulse", rsp_valid, 2'b00);
    chk("drop_no_latch", mem_addr, 32'h400);
    // both requesters storing continuously: grants alternate 0,1,0,1
    req_write = 2'b11; req_addr[0] = 32'h200; req_addr[1] = 32'h300;
    req_wdata[0] = 32'hA0A0A0A0; req_wdata[1] = 32'hB1B1B1B1; req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] g;
      g = (i % 2 == 1) ? 2'b10 : 2'b01;
      chk($sformatf("rr_ready%0d", i), req_ready, g);
      tick();
      chk($sformatf("rr_disp_wr%0d", i), {mem_dispatch_write, mem_dispatch_read}, 2'b10);
      chk($sformatf("rr_wdata%0d", i), mem_write_data, (i % 2 == 1) ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
      chk($sformatf("rr_addr%0d", i), mem_addr, (i % 2 == 1) ? 32'h300 : 32'h200);
      tick(); mem_busy = 1'b1;
      tick(); mem_busy = 1'b0;
      tick();
      chk($sformatf("rr_rsp%0d", i), rsp_valid, g);
      chk($sformatf("rr_rdata%0d", i), rsp_rdata, 0);
    end
    req_valid = 2'b00;
    tick();
    // back-to-back CPU loads with one busy cycle
    req_write = 2'b00; req_addr[0] = 32'h600; req_valid = 2'b01;
    #1 chk("b2b_ready", req_ready, 2'b01);
    tick();
    chk("b2b_disp0", mem_dispatch_read, 1);
    c0 = cyc;
    tick(); mem_busy = 1'b1;
    tick(); mem_busy = 1'b0; mem_read_data = 32'h11111111;
    tick();
    chk("b2b_rsp0", rsp_valid, 2'b01);
    chk("b2b_rdata0", rsp_rdata, 32'h11111111);
    chk("b2b_overlap", req_ready, 2'b01);
    tick();
    chk("b2b_disp1", mem_dispatch_read, 1);
    chk("b2b_spacing", cyc - c0, 4);
    tick(); mem_busy = 1'b1;
    tick(); mem_busy = 1'b0; mem_read_data = 32'h22222222;
    tick(); req_valid = 2'b00;
    chk("b2b_rsp1", rsp_valid, 2'b01);
    chk("b2b_rdata1", rsp_rdata, 32'h22222222);
    tick();
    // reset asserted during WAIT
    req_addr[1] = 32'h500; req_valid = 2'b10;
    #1 chk("rw_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    tick(); mem_busy = 1'b1;
    #2 rst_in = 1'b0;
    #1;
    chk("rw_addr", mem_addr, 0);
    chk("rw_dispatch", {mem_dispatch_read, mem_dispatch_write}, 2'b00);
    chk("rw_rsp", rsp_valid, 2'b00);
    chk("rw_rdata", rsp_rdata, 0);
    mem_busy = 1'b0; req_valid = 2'b01; #1;
    chk("rw_ready_gate", req_ready, 2'b00);
    req_valid = 2'b00;
    tick(); rst_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rw_no_rsp%0d", i), rsp_valid, 2'b00);
    end
    req_valid = 2'b11;
    #1 chk("rw_ptr_reset", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    chk("rw_disp", mem_dispatch_read, 1);
    chk("rw_new_addr", mem_addr, 32'h600);
    tick(); mem_busy = 1'b1;
    tick(); mem_busy = 1'b0; mem_read_data = 32'h33333333;
    tick();
    chk("rw_rsp_valid", rsp_valid, 2'b01);
    chk("rw_rsp_rdata", rsp_rdata, 32'h33333333);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
